// File: rtl/rf_read_port_scheduler_if.sv
// Request, RF read-port and operand-return signals of rf_read_port_scheduler.
// The scheduler connects through the slave modport.
interface rf_read_port_scheduler_if #(
    parameter int NUM_REQ   = 6,
    parameter int NUM_PORTS = 2,
    parameter int PREG_W    = 6,
    parameter int DATA_W    = 32
);
    logic                                i_flush;
    logic [NUM_REQ-1:0]                  i_req_valid;
    logic [NUM_REQ-1:0][PREG_W-1:0]      i_req_preg;
    logic [NUM_PORTS-1:0]                o_rf_ren;
    logic [NUM_PORTS-1:0][PREG_W-1:0]    o_rf_raddr;
    logic [NUM_PORTS-1:0][DATA_W-1:0]    i_rf_rdata;
    logic [NUM_REQ-1:0]                  o_data_valid;
    logic [NUM_REQ-1:0][DATA_W-1:0]      o_data;
    logic                                o_busy;

    modport slave (
        input  i_flush, i_req_valid, i_req_preg, i_rf_rdata,
        output o_rf_ren, o_rf_raddr, o_data_valid, o_data, o_busy
    );

    modport master (
        output i_flush, i_req_valid, i_req_preg, i_rf_rdata,
        input  o_rf_ren, o_rf_raddr, o_data_valid, o_data, o_busy
    );
endinterface

// File: rtl/rf_read_port_scheduler.sv
// Round-robin scheduler of operand reads onto the RF read ports, coalescing
// same-register requests and returning data two cycles after the request.
module rf_read_port_scheduler #(
    parameter int NUM_REQ   = 6,
    parameter int NUM_PORTS = 2,
    parameter int PREG_W    = 6,
    parameter int DATA_W    = 32
) (
    input logic                     clk,
    input logic                     reset,
    rf_read_port_scheduler_if.slave bus
);
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Per-requester owner entry: zero marks an x0 read that never used a port.
    typedef struct packed {
        logic              valid;
        logic              zero;
        logic [PORT_W-1:0] port;
    } slot_t;

    slot_t [NUM_REQ-1:0]              s1_q, s1_d, s2_q;
    logic  [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic  [NUM_PORTS-1:0]            ren_q, ren_d;
    logic  [NUM_PORTS-1:0][PREG_W-1:0] raddr_q, raddr_d;
    logic  [NUM_REQ-1:0]              eligible;
    logic  [PTR_W-1:0]                scan_idx;
    logic  [PREG_W-1:0]               scan_preg;
    logic                             matched;
    logic                             placed;
    logic                             busy;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = bus.i_req_valid[i] & ~s1_q[i].valid & ~s2_q[i].valid;
        end
    end

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path infers a latch.
        s1_d      = '0;
        ren_d     = '0;
        raddr_d   = raddr_q;
        rr_ptr_d  = rr_ptr_q;
        scan_idx  = '0;
        scan_preg = '0;
        matched   = 1'b0;
        placed    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx  = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            scan_preg = bus.i_req_preg[scan_idx];
            if (eligible[scan_idx]) begin
                if (scan_preg == '0) begin
                    s1_d[scan_idx].valid = 1'b1;
                    s1_d[scan_idx].zero  = 1'b1;
                end else begin
                    matched = 1'b0;
                    placed  = 1'b0;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (!matched && ren_d[p] && raddr_d[p] == scan_preg) begin
                            matched              = 1'b1;
                            s1_d[scan_idx].valid = 1'b1;
                            s1_d[scan_idx].port  = PORT_W'(p);
                        end
                    end
                    // Ports fill in order, so the first idle one is the next free port.
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (!matched && !placed && !ren_d[p]) begin
                            placed               = 1'b1;
                            ren_d[p]             = 1'b1;
                            raddr_d[p]           = scan_preg;
                            s1_d[scan_idx].valid = 1'b1;
                            s1_d[scan_idx].port  = PORT_W'(p);
                            rr_ptr_d = (int'(scan_idx) == NUM_REQ - 1) ? '0 : scan_idx + 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so s2_q captures the pre-edge s1_q, forming a true two-stage pipe.
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            ren_q    <= '0;
            raddr_q  <= '0;
            rr_ptr_q <= '0;
        end else if (bus.i_flush) begin
            s1_q  <= '0;
            s2_q  <= '0;
            ren_q <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s1_q;
            ren_q    <= ren_d;
            raddr_q  <= raddr_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Data is steered from the registered owner map onto the RF data returning this cycle.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            busy                 = busy | s1_q[i].valid | s2_q[i].valid;
            bus.o_data_valid[i]  = s2_q[i].valid;
            bus.o_data[i]        = (s2_q[i].valid && !s2_q[i].zero) ?
                                   bus.i_rf_rdata[s2_q[i].port] : '0;
        end
    end

    assign bus.o_rf_ren   = ren_q;
    assign bus.o_rf_raddr = raddr_q;
    assign bus.o_busy     = busy;

endmodule

// File: tb/tb_rf_read_port_scheduler.sv
// Scoreboard bench: a queue/arithmetic reference model predicts port usage and
// per-requester data; a negedge monitor compares every cycle.
module tb_rf_read_port_scheduler;
    localparam int NUM_REQ   = 6;
    localparam int NUM_PORTS = 2;
    localparam int PREG_W    = 6;
    localparam int DATA_W    = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rf_read_port_scheduler_if #(.NUM_REQ(NUM_REQ), .NUM_PORTS(NUM_PORTS),
                                .PREG_W(PREG_W), .DATA_W(DATA_W)) bus ();

    rf_read_port_scheduler #(.NUM_REQ(NUM_REQ), .NUM_PORTS(NUM_PORTS),
                             .PREG_W(PREG_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int                due;
        int                req;
        logic [DATA_W-1:0] data;
    } data_exp_t;

    typedef struct {
        int                               due;
        logic [NUM_PORTS-1:0]             ren;
        logic [NUM_PORTS-1:0][PREG_W-1:0] addr;
    } port_exp_t;

    data_exp_t         data_q[$];
    port_exp_t         port_q[$];
    logic [DATA_W-1:0] mem [64];
    int                until_c [NUM_REQ];
    bit                pending [NUM_REQ];
    bit                want_valid [NUM_REQ];
    logic [PREG_W-1:0] want_preg [NUM_REQ];
    int                rr;
    int                cyc;
    int                n_cmp;
    int                n_fail;
    bit                mon_en;
    bit                prev_kill;
    logic [NUM_PORTS-1:0]             prev_ren;
    logic [NUM_PORTS-1:0][PREG_W-1:0] prev_raddr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Advance one cycle; the RF model answers the addresses presented last cycle.
    task automatic tick();
        data_exp_t keep[$];
        @(posedge clk);
        #1;
        cyc++;
        if (prev_kill) begin
            foreach (data_q[j]) if (data_q[j].due < cyc) keep.push_back(data_q[j]);
            data_q = keep;
        end
        prev_kill = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++)
            bus.i_rf_rdata[p] = prev_ren[p] ? mem[prev_raddr[p]] : DATA_W'($urandom);
        prev_ren   = bus.o_rf_ren;
        prev_raddr = bus.o_rf_raddr;
    endtask

    // Drive this cycle's inputs and predict the scheduler's decision for them.
    task automatic issue(input bit flush, input bit rst);
        logic [PREG_W-1:0] ports[$];
        port_exp_t         pe;
        data_exp_t         de;
        int                idx;
        int                last_new;
        bit                got;
        logic [PREG_W-1:0] preg;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!(until_c[i] >= cyc || pending[i])) begin
                bus.i_req_valid[i] = want_valid[i];
                bus.i_req_preg[i]  = want_preg[i];
            end
        end
        bus.i_flush = flush;
        reset       = rst;
        if (rst || flush) begin
            if (rst) rr = 0;
            for (int i = 0; i < NUM_REQ; i++) if (until_c[i] > cyc) until_c[i] = cyc;
            prev_kill = 1'b1;
            return;
        end
        last_new = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (rr + k) % NUM_REQ;
            if (!(bus.i_req_valid[idx] && until_c[idx] < cyc)) continue;
            preg = bus.i_req_preg[idx];
            got  = (preg == '0);
            if (!got) begin
                foreach (ports[p]) if (ports[p] == preg) got = 1'b1;
                if (!got && ports.size() < NUM_PORTS) begin
                    ports.push_back(preg);
                    got      = 1'b1;
                    last_new = idx;
                end
            end
            if (got) begin
                de.due  = cyc + 2;
                de.req  = idx;
                de.data = (preg == '0) ? '0 : mem[preg];
                data_q.push_back(de);
                until_c[idx] = cyc + 2;
                pending[idx] = 1'b0;
            end else begin
                pending[idx] = 1'b1;
            end
        end
        pe.due  = cyc + 1;
        pe.ren  = '0;
        pe.addr = '0;
        foreach (ports[p]) begin
            pe.ren[p]  = 1'b1;
            pe.addr[p] = ports[p];
        end
        if (ports.size() > 0) port_q.push_back(pe);
        if (last_new >= 0) rr = (last_new + 1) % NUM_REQ;
    endtask

    task automatic step(input bit flush, input bit rst);
        tick();
        issue(flush, rst);
    endtask

    task automatic clear_want();
        for (int i = 0; i < NUM_REQ; i++) want_valid[i] = 1'b0;
    endtask

    // One-shot request pattern, then let the held requests drain.
    task automatic scenario(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*PREG_W-1:0] pr, input int n);
        for (int i = 0; i < NUM_REQ; i++) begin
            want_valid[i] = v[i];
            want_preg[i]  = pr[i*PREG_W +: PREG_W];
        end
        step(1'b0, 1'b0);
        clear_want();
        repeat (n) step(1'b0, 1'b0);
    endtask

    always @(negedge clk) begin : monitor
        logic [NUM_REQ-1:0] exp_dv;
        logic [DATA_W-1:0]  exp_d [NUM_REQ];
        bit                 exp_busy;
        data_exp_t          e;
        port_exp_t          pe;
        if (mon_en) begin
            exp_busy = 1'b0;
            foreach (data_q[j]) if (data_q[j].due == cyc || data_q[j].due == cyc + 1) exp_busy = 1'b1;
            exp_dv = '0;
            while (data_q.size() > 0 && data_q[0].due <= cyc) begin
                e = data_q.pop_front();
                if (e.due == cyc) begin
                    exp_dv[e.req] = 1'b1;
                    exp_d[e.req]  = e.data;
                end
            end
            check("data_valid", 64'(bus.o_data_valid), 64'(exp_dv));
            for (int i = 0; i < NUM_REQ; i++)
                if (exp_dv[i] && bus.o_data_valid[i])
                    check($sformatf("data[%0d]", i), 64'(bus.o_data[i]), 64'(exp_d[i]));
            check("busy", 64'(bus.o_busy), 64'(exp_busy));
            if (port_q.size() > 0 && port_q[0].due == cyc) begin
                pe = port_q.pop_front();
                check("rf_ren", 64'(bus.o_rf_ren), 64'(pe.ren));
                for (int p = 0; p < NUM_PORTS; p++)
                    if (pe.ren[p]) check($sformatf("rf_raddr[%0d]", p), 64'(bus.o_rf_raddr[p]), 64'(pe.addr[p]));
            end else begin
                check("rf_ren_idle", 64'(bus.o_rf_ren), 64'd0);
            end
            for (int i = 0; i < NUM_REQ; i++)
                assert (!(until_c[i] >= cyc && !bus.i_req_valid[i]))
                    else $error("protocol violation: requester %0d dropped its request in flight", i);
        end
    end

    initial begin
        bus.i_flush     = 1'b0;
        bus.i_req_valid = '0;
        bus.i_req_preg  = '0;
        bus.i_rf_rdata  = '0;
        for (int a = 0; a < 64; a++) mem[a] = DATA_W'($urandom);
        mem[0] = 32'hBADC_0FFE;
        mem[5] = 32'h0000_DEAD;
        for (int i = 0; i < NUM_REQ; i++) begin
            until_c[i]    = -10;
            pending[i]    = 1'b0;
            want_valid[i] = 1'b0;
            want_preg[i]  = '0;
        end
        rr = 0; cyc = 0; n_cmp = 0; n_fail = 0; mon_en = 1'b0; prev_kill = 1'b0;
        prev_ren = '0; prev_raddr = '0;

        step(1'b0, 1'b1);
        mon_en = 1'b1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("reset_raddr", 64'(bus.o_rf_raddr), 64'd0);

        // Single request, preg 5 returns 0xDEAD two cycles later.
        scenario(6'b000001, {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd5}, 4);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        // Oversubscription from rr_ptr 0: {0,1} then {2,3}.
        scenario(6'b001111, {6'd0, 6'd0, 6'd4, 6'd3, 6'd2, 6'd1}, 6);
        // Coalescing: req0/2/4 share preg 9, req1 reads preg 7.
        scenario(6'b010111, {6'd0, 6'd9, 6'd0, 6'd9, 6'd7, 6'd9}, 4);
        // x0: req3 reads preg 0, req5 preg 12.
        scenario(6'b101000, {6'd12, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0}, 4);

        // Flush the cycle after a grant, then re-request.
        want_valid[1] = 1'b1; want_preg[1] = 6'd20;
        step(1'b0, 1'b0);
        clear_want();
        step(1'b1, 1'b0);
        want_valid[1] = 1'b1; want_preg[1] = 6'd21;
        step(1'b0, 1'b0);
        clear_want();
        repeat (4) step(1'b0, 1'b0);

        // Reset with two reads in flight.
        want_valid[0] = 1'b1; want_preg[0] = 6'd30;
        want_valid[1] = 1'b1; want_preg[1] = 6'd31;
        step(1'b0, 1'b0);
        clear_want();
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("midreset_raddr", 64'(bus.o_rf_raddr), 64'd0);
        check("midreset_ren", 64'(bus.o_rf_ren), 64'd0);
        repeat (3) step(1'b0, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                want_valid[i] = ($urandom_range(0, 2) != 0);
                want_preg[i]  = ($urandom_range(0, 7) == 0) ? PREG_W'($urandom) : PREG_W'($urandom_range(0, 7));
            end
            step($urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);
        end
        clear_want();
        repeat (8) step(1'b0, 1'b0);
        check("drain_data", 64'(data_q.size()), 64'd0);
        check("drain_ports", 64'(port_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_read_port_scheduler.md
Name: rf_read_port_scheduler

Overview:
- Arbitrates issue-stage operand read requests onto the limited physical register-file read ports; feeds rf_selector_module-style port selection with a sequenced, fair schedule.
- Round-robin over requesters; requests for the same physical register are coalesced onto one port.
- Tracks each request in flight through the 1-cycle synchronous RF read and returns data per requester.

Parameters:
NUM_REQ, 6, number of operand requesters (3 issue slots x 2 operands)
NUM_PORTS, 2, physical RF read ports
PREG_W, 6, physical register tag width
DATA_W, 32, register data width

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
i_flush  in  1  pipeline flush; kills all in-flight reads
i_req_valid  in  NUM_REQ  per-requester request, level, held until o_data_valid
i_req_preg  in  NUM_REQ x PREG_W  physical register tag, stable while valid
o_rf_ren  out  NUM_PORTS  read enable per RF port
o_rf_raddr  out  NUM_PORTS x PREG_W  read address per RF port
i_rf_rdata  in  NUM_PORTS x DATA_W  RF data, valid the cycle after o_rf_ren
o_data_valid  out  NUM_REQ  operand data delivered this cycle
o_data  out  NUM_REQ x DATA_W  operand data, meaningful only with o_data_valid
o_busy  out  1  any request in flight

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset: o_rf_ren=0, o_rf_raddr=0, o_data_valid=0, o_data=0, o_busy=0, all in-flight state cleared, rr_ptr=0. Reset mid-operation drops all in-flight requests with no data delivered.
- Eligibility: requester i is eligible when i_req_valid[i]=1 and i is not in flight. A requester is in flight from its grant edge through its o_data_valid cycle. i_req_valid still high in the cycle after o_data_valid is a new request.
- Arbitration (combinational on inputs and state, registered at the edge):
  - Scan eligible requesters in order rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Each new distinct nonzero preg takes the next free port, up to NUM_PORTS.
  - Every eligible requester whose preg equals a port's selected preg is granted on that port (coalescing; no extra port used).
- Preg 0 (x0): never consumes a port. Eligible requesters with preg 0 are always granted and receive o_data=0 on the same timing as port reads.
- Timing: request eligible in cycle 0 -> o_rf_ren/o_rf_raddr registered, high in cycle 1 -> o_data_valid[i]=1 in cycle 2, with o_data[i]=i_rf_rdata[port(i)], selected combinationally from the registered owner map.
  - Minimum latency is 2 cycles.
  - Back-to-back issue every cycle: the port pipeline is fully pipelined (stage1 address, stage2 data owner).
- rr_ptr update: on any cycle with at least one port-consuming grant, rr_ptr <= (index of the last requester in scan order that took a new port) + 1 mod NUM_REQ. Coalesced and x0 grants do not move rr_ptr. rr_ptr is unchanged otherwise.
- Unused ports: o_rf_ren=0; o_rf_raddr holds its previous value.
- Flush: takes priority over new grants in the same cycle.
  - Next cycle: o_rf_ren=0 and o_data_valid=0.
  - Both pipeline stages are cleared; data returning for flushed reads is discarded.
  - rr_ptr is unaffected.
  - Requesters may re-request from the cycle after flush.
- o_busy = OR of stage1 and stage2 valid.
- Requester dropping i_req_valid while in flight: protocol violation. The data is still delivered; the bench asserts the violation.

Test Plan:
- Single request: req0 preg=5 in cycle 0 -> cycle 1 o_rf_ren=01, raddr0=5; i_rf_rdata0=0xDEAD in cycle 1 -> cycle 2 o_data_valid=000001, o_data[0]=0xDEAD.
- Oversubscription with round-robin: req0..3 pregs 1,2,3,4 held, rr_ptr=0 -> grants {0,1} at cycle 0, rr_ptr=2; {2,3} next; each requester gets data exactly once; rr_ptr rotates 0->2->4.
- Coalescing: req0, req2, req4 all preg=9, req1 preg=7 -> one cycle, ports raddr={9,7}; o_data_valid=010111 in cycle 2, all three preg-9 requesters get port0 data.
- x0 handling: req3 preg=0 and req5 preg=12 -> only port0 used (raddr=12); req3 gets o_data=0 with o_data_valid in cycle 2.
- Flush mid-flight: grant at cycle 0, i_flush=1 in cycle 1 -> no o_data_valid in cycle 2, o_busy=0 in cycle 2, rr_ptr preserved; re-request in cycle 2 is granted normally.
- Reset mid-operation: reset=1 with 2 reads in flight -> next cycle all outputs 0, rr_ptr=0; no o_data_valid for the pre-reset requests.
